// File: rtl/breath_led_multi.sv
// rtl/breath_led_multi.sv - multi-channel breathing-LED PWM engine; optional gamma via BREATH_LED_GAMMA_EN
module breath_led_multi #(
  parameter int CHANNELS = 4,
  parameter int PWM_W    = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [1:0]          speed,
  output logic [CHANNELS-1:0] led_n,
  output logic                cycle_done
);

  localparam logic [1:0]       MODE_OFF    = 2'b00;
  localparam logic [1:0]       MODE_ON     = 2'b01;
  localparam logic [1:0]       MODE_BREATH = 2'b10;
  localparam logic [1:0]       MODE_ALT    = 2'b11;
  localparam logic [PWM_W-1:0] MAX         = {PWM_W{1'b1}};

  logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic [PWM_W-1:0]    level_q, level_d;
  logic                dir_q, dir_d;
  logic [CHANNELS-1:0] led_n_q, led_n_d;
  logic                done_q, done_d;

  logic                wrap;
  logic                entering;
  logic                running;
  logic [PWM_W:0]      step_w;
  logic [PWM_W:0]      sum_w;
  logic [PWM_W:0]      diff_w;
  logic [PWM_W-1:0]    duty [CHANNELS];

  assign wrap      = (pwm_cnt_q == MAX);
  assign pwm_cnt_d = pwm_cnt_q + 1'b1;
  // Breath modes have bit 1 set; entry restarts the breath from the trough.
  assign entering  = mode[1] && !mode_q[1];
  // The engine only steps on a wrap where a breath mode persists through it.
  assign running   = mode_q[1] && mode[1];
  assign step_w    = (PWM_W+1)'(1) << speed;
  assign sum_w     = {1'b0, level_q} + step_w;
  assign diff_w    = {1'b0, level_q} - step_w;

  // Next-state for mode, level, direction and the breath-complete flag; all change only on wrap.
  always_comb begin
    mode_d  = mode_q;
    level_d = level_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (wrap) begin
      mode_d = mode;
      if (entering) begin
        level_d = '0;
        dir_d   = 1'b1;
      end else if (running) begin
        if (dir_q) begin
          if (level_q == MAX)           dir_d   = 1'b0;
          else if (sum_w > {1'b0, MAX}) level_d = MAX;
          else                          level_d = sum_w[PWM_W-1:0];
        end else begin
          if (level_q == '0) begin
            dir_d  = 1'b1;
            done_d = 1'b1;
          end else if (diff_w[PWM_W]) begin
            level_d = '0;
          end else begin
            level_d = diff_w[PWM_W-1:0];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam bit ODD = (i % 2) == 1;
`ifdef BREATH_LED_GAMMA_EN
    logic [PWM_W-1:0]   lvl_n;
    logic [2*PWM_W-1:0] sq;
    logic [PWM_W-1:0]   duty_q;
    assign lvl_n = (mode_d == MODE_ALT && ODD) ? (MAX - level_d) : level_d;
    assign sq    = {{PWM_W{1'b0}}, lvl_n} * {{PWM_W{1'b0}}, lvl_n};
    // Square the upcoming period's level at wrap so the compare sees only a register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)      duty_q <= '0;
      else if (wrap) duty_q <= PWM_W'(sq >> PWM_W);
    end
    assign duty[i] = duty_q;
`else
    logic [PWM_W-1:0] lvl_c;
    assign lvl_c   = (mode_q == MODE_ALT && ODD) ? (MAX - level_q) : level_q;
    assign duty[i] = lvl_c;
`endif
  end

  // Per-channel LED drive for the current counter value, registered one clock later.
  always_comb begin
    led_n_d = '1;
    for (int c = 0; c < CHANNELS; c++) begin
      case (mode_q)
        MODE_OFF:              led_n_d[c] = 1'b1;
        MODE_ON:               led_n_d[c] = 1'b0;
        MODE_BREATH, MODE_ALT: led_n_d[c] = !(pwm_cnt_q < duty[c]);
        default:               led_n_d[c] = 1'b1;
      endcase
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt_q <= '0;
      mode_q    <= MODE_OFF;
      level_q   <= '0;
      dir_q     <= 1'b1;
      led_n_q   <= '1;
      done_q    <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      mode_q    <= mode_d;
      level_q   <= level_d;
      dir_q     <= dir_d;
      led_n_q   <= led_n_d;
      done_q    <= done_d;
    end
  end

  assign led_n      = led_n_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_breath_led_multi.sv
// tb/tb_breath_led_multi.sv - period-level reference model check of breath_led_multi
module tb_breath_led_multi;

  localparam int CH   = 4;
  localparam int W    = 4;
  localparam int MAXV = 15;
  localparam int PER  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    mode = 2'b10;
  logic [1:0]    speed = 2'b00;
  logic [CH-1:0] led_n;
  logic          cycle_done;

  int vectors = 0;
  int miscompares = 0;
  int period = 0;

  // Reference state: mode in force, brightness level and direction of travel.
  int m_mode = 0;
  int m_lvl  = 0;
  int m_dir  = 1;

  always #5 clk = ~clk;

  breath_led_multi #(.CHANNELS(CH), .PWM_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .speed      (speed),
    .led_n      (led_n),
    .cycle_done (cycle_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int expected_low(input int c);
    int l;
    if (m_mode == 0) return 0;
    if (m_mode == 1) return PER;
    l = (m_mode == 3 && (c % 2) == 1) ? MAXV - m_lvl : m_lvl;
`ifdef BREATH_LED_GAMMA_EN
    l = (l * l) >> W;
`endif
    return l;
  endfunction

  // One period boundary: the mode present at the boundary takes effect, and a
  // breath that persists moves one step toward its peak or trough.
  task automatic model_wrap(input int mi, input int si, output bit done);
    int st;
    st   = 1 << si;
    done = 1'b0;
    if (mi >= 2 && m_mode < 2) begin
      m_lvl = 0;
      m_dir = 1;
    end else if (mi >= 2 && m_mode >= 2) begin
      if (m_dir == 1) begin
        if (m_lvl == MAXV) m_dir = 0;
        else m_lvl = (m_lvl + st > MAXV) ? MAXV : m_lvl + st;
      end else begin
        if (m_lvl == 0) begin
          m_dir = 1;
          done  = 1'b1;
        end else begin
          m_lvl = (m_lvl - st < 0) ? 0 : m_lvl - st;
        end
      end
    end
    m_mode = mi;
  endtask

  task automatic run_period(input logic [1:0] mi, input logic [1:0] si, input bit glitch);
    int          exp_low[CH];
    int          low[CH];
    logic [15:0] cd_mask;
    int          chg;
    bit          done;
    for (int c = 0; c < CH; c++) begin
      exp_low[c] = expected_low(c);
      low[c]     = 0;
    end
    cd_mask = '0;
    chg     = $urandom_range(3, 14);
    for (int k = 1; k <= PER; k++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) if (led_n[c] === 1'b0) low[c]++;
      cd_mask[k-1] = cycle_done;
      if (glitch && k == 2) begin
        mode  = 2'($urandom_range(0, 3));
        speed = 2'($urandom_range(0, 3));
      end
      if (k == chg) begin
        mode  = mi;
        speed = si;
      end
    end
    model_wrap(int'(mi), int'(si), done);
    for (int c = 0; c < CH; c++)
      check_val($sformatf("low_ch%0d_p%0d", c, period), low[c], exp_low[c]);
    check_val($sformatf("done_p%0d", period), {16'h0, cd_mask}, done ? 32'h8000 : 32'h0);
    period++;
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_lvl  = 0;
    m_dir  = 1;
  endtask

  initial begin
    logic [1:0] tgt;
    // Held in reset with breath requested: outputs stay idle.
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_led_n", {28'h0, led_n}, 32'hF);
    check_val("reset_done", {31'h0, cycle_done}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Coarse steps with saturation at both ends.
    for (int i = 0; i < 8; i++) run_period(2'b10, 2'd3, 1'b0);
    // Unit steps over a full breath and a bit.
    for (int i = 0; i < 36; i++) run_period(2'b10, 2'd0, 1'b0);
    // Alternate, then back to in-phase breath without restarting.
    for (int i = 0; i < 12; i++) run_period(2'b11, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) run_period(2'b10, 2'd1, 1'b0);
    // Steady on, off with short-lived mode glitches, then steady on again.
    for (int i = 0; i < 2; i++) run_period(2'b01, 2'd2, 1'b0);
    for (int i = 0; i < 2; i++) run_period(2'b00, 2'd2, 1'b1);
    for (int i = 0; i < 2; i++) run_period(2'b01, 2'd0, 1'b0);

    // Asynchronous reset while every LED is lit.
    repeat ($urandom_range(1, 8)) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_val("async_rst_led_n", {28'h0, led_n}, 32'hF);
    check_val("async_rst_done", {31'h0, cycle_done}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) run_period(2'b10, 2'd2, 1'b0);

    // Randomized traffic: mostly persistent breath modes with occasional changes.
    tgt = 2'b11;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) tgt = 2'($urandom_range(0, 3));
      run_period(tgt, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/breath_led_multi.md
# breath_led_multi

Parametrised multi-channel breathing-LED PWM engine for the board LED bank. It generalises the fixed-rate single-pair breathing driver with several additions: a configurable channel count and PWM resolution, run-time mode and speed selection, glitch-free mode switching at PWM period boundaries, and a breath-complete pulse. It sits between the top-level mode/status logic and the active-low LED pins.

## Interface
- CHANNELS, 4: number of LED outputs (1..16).
- PWM_W, 12: PWM counter width. PWM period is 2^PWM_W clocks; brightness level range is 0..MAX with MAX = 2^PWM_W-1.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- mode  input  2  00 off, 01 steady on, 10 breath (all channels in phase), 11 alternate (odd channels anti-phase).
- speed  input  2  level step per PWM period = 1<<speed (1, 2, 4, 8).
- led_n  output  CHANNELS  active-low LED drive, registered.
- cycle_done  output  1  one-clock pulse when a full breath (rise, peak, fall, trough) completes.

## Operation
- pwm_cnt (PWM_W bits) increments every clk and wraps MAX→0. wrap = (pwm_cnt == MAX).
- mode_q is loaded from mode only on wrap. speed is sampled on wrap.
- Level engine: level (PWM_W bits), dir (1 = rising). It updates only on wrap while mode_q is 10 or 11:
  - rising, level == MAX: dir←0, level holds.
  - rising, otherwise: level ← min(level+step, MAX).
  - falling, level == 0: dir←1, level holds, cycle_done=1 for that clock.
  - falling, otherwise: level ← max(level−step, 0).
  - Compute sums and differences in PWM_W+1 bits. No wrap-around of level is permitted.
- Entering breath or alternate from off or steady on (mode_q changes on a wrap): level←0 and dir←1 in that same wrap, and the level engine does not step in that wrap. Switching between 10 and 11 keeps level and dir.
- In off or steady-on: level and dir freeze, and cycle_done stays 0.
- Per-channel level: lvl_i = level, except in mode_q 11 with odd i, where lvl_i = MAX − level.
- duty_i = lvl_i (see Configuration).
- Channel i is lit when pwm_cnt < duty_i. duty MAX lights MAX of 2^PWM_W clocks; duty 0 is fully dark.
- led_n[i] is registered:
  - mode_q 00: 1.
  - mode_q 01: 0.
  - else: ~(pwm_cnt < duty_i).

## Timing
- Reset values: pwm_cnt 0, level 0, dir 1, mode_q 00, led_n all 1, cycle_done 0. Asserting rst mid-operation returns every state bit to these values immediately (asynchronously). After release, the first count happens on the first clk edge.
- led_n latency: 1 clk after the pwm_cnt value it is compared against.
- A mode change becomes visible on led_n one clk after the wrap that loads it, i.e. aligned with pwm_cnt = 0 of the new period. mode changes that do not persist through a wrap are ignored.
- cycle_done is asserted in the clock following the wrap edge where the falling→rising flip occurs, for exactly 1 clk.
- A breath at step s takes 2·ceil(MAX/s) + 2 PWM periods.

## Configuration
- BREATH_LED_GAMMA_EN defined: duty_i = (lvl_i · lvl_i) >> PWM_W. The product is 2·PWM_W bits wide and is registered once per period at wrap, so it adds no combinational path into the compare. Brightness is perceptually linear.
- Not defined: duty_i = lvl_i (linear). The multiplier is absent.

## Test plan
- Reset: hold rst low with mode=10 → led_n all 1, cycle_done 0. Release → pwm_cnt counts 0,1,2…; led_n stays all 1 until the first wrap loads mode.
- Steady on (PWM_W=4, mode=01): after the first wrap → led_n all 0 from pwm_cnt=0 onward. Switch to 00 mid-period → led_n stays 0 until the next wrap, then all 1.
- Breath (PWM_W=4, speed=0, mode=10): level goes 0..15 over periods 1..15, holds at 15 for period 16, falls to 0 by period 31, flips at period 32 with a single cycle_done pulse. At level 5, each led_n is low for exactly 5 of 16 clocks.
- Speed and saturation (PWM_W=4, speed=3): level sequence 0, 8, 15, 15(flip), 7, 0, 0(flip + cycle_done).
- Alternate (CHANNELS=2, PWM_W=4, mode=11, linear): for every period, low clocks of led_n[0] + low clocks of led_n[1] = 15. Switching 11→10 at level 9 continues from 9 without restarting.
- Gamma (BREATH_LED_GAMMA_EN, PWM_W=4): level 8 → 4 low clocks per period; level 15 → 14. Without the macro: 8 and 15. Asserting rst at level 12 → led_n all 1 immediately, and level 0 after release.
